// File: rtl/snd_spi_ctrl.sv
// snd_spi_ctrl: bridges an external SPI panel onto the sound block's register write port, merged with host writes.
// Define SNDCTL_VOLSTEP_EN to add the shadow volume register and the relative volume opcodes 05/06.
module snd_spi_ctrl #(
    parameter logic [15:0] ADDR_BASE = 16'h3000,
    parameter logic [7:0]  VOL_STEP  = 8'h10
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        SCK,
    input  logic        SSEL,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] H_WRADDR,
    input  logic [3:0]  H_BYTEEN,
    input  logic        H_WREN,
    input  logic [31:0] H_WDATA,
    output logic [15:0] WRADDR,
    output logic [3:0]  BYTEEN,
    output logic        WREN,
    output logic [31:0] WDATA,
    output logic        BUSY,
    output logic        FRAME_ERR
);

    // state    | meaning
    // S_IDLE   | no frame being received, no SPI write pending
    // S_SHIFT  | SSEL low, frame bits being collected
    // S_DECODE | one cycle after SSEL rise: length/opcode check
    // S_ISSUE  | SPI write pending, waits for a cycle with no host write
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE, S_ISSUE} state_t;

    localparam logic [15:0] A_START = ADDR_BASE;
    localparam logic [15:0] A_SIZE  = ADDR_BASE + 16'h0004;
    localparam logic [15:0] A_VOL   = ADDR_BASE + 16'h0008;
    localparam logic [15:0] A_CMD   = ADDR_BASE + 16'h000C;

    logic [2:0]  r_sck_sync;
    logic [2:0]  r_ssel_sync;
    logic [2:0]  r_mosi_sync;
    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_ssel_rise;
    logic        w_ssel_fall;
    logic        w_frame_end;

    logic        r_live;
    logic        r_armed;
    logic        r_in_frame;
    logic [5:0]  r_bit_cnt;
    logic [39:0] r_shift;
    logic [7:0]  r_tx;
    logic        r_miso;
    logic [7:0]  r_result;

    state_t      r_state;
    logic        r_wren;
    logic        r_busy;
    logic        r_frame_err;
    logic [15:0] r_wraddr;
    logic [3:0]  r_byteen;
    logic [31:0] r_wdata;
    logic [15:0] r_pend_addr;
    logic [31:0] r_pend_data;

    logic [7:0]  w_op;
    logic [31:0] w_arg;
    logic        w_dec_ok;
    logic [15:0] w_dec_addr;
    logic [31:0] w_dec_data;

`ifdef SNDCTL_VOLSTEP_EN
    logic [7:0]  r_vol;
    logic [8:0]  w_vol_sum;
    logic [7:0]  w_vol_up;
    logic [7:0]  w_vol_dn;

    always_comb begin
        w_vol_sum = {1'b0, r_vol} + {1'b0, VOL_STEP};
        w_vol_up  = w_vol_sum[8] ? 8'hFF : w_vol_sum[7:0];
        w_vol_dn  = (r_vol < VOL_STEP) ? 8'h00 : (r_vol - VOL_STEP);
    end
`else
    logic w_unused_vol_step;
    assign w_unused_vol_step = ^VOL_STEP;
`endif

    assign w_sck_rise  =  r_sck_sync[1]  & ~r_sck_sync[2];
    assign w_sck_fall  = ~r_sck_sync[1]  &  r_sck_sync[2];
    assign w_ssel_rise =  r_ssel_sync[1] & ~r_ssel_sync[2];
    assign w_ssel_fall = ~r_ssel_sync[1] &  r_ssel_sync[2];
    assign w_frame_end =  w_ssel_rise & r_in_frame;

    // Arming needs SSEL seen high by a flop that has sampled the pin since reset,
    // so a frame already in progress at reset release is never picked up mid-way.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_sck_sync  <= 3'b000;
            r_ssel_sync <= 3'b111;
            r_mosi_sync <= 3'b000;
            r_live      <= 1'b0;
            r_armed     <= 1'b0;
            r_in_frame  <= 1'b0;
            r_bit_cnt   <= 6'd0;
            r_shift     <= 40'd0;
            r_tx        <= 8'h00;
            r_miso      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], SCK};
            r_ssel_sync <= {r_ssel_sync[1:0], SSEL};
            r_mosi_sync <= {r_mosi_sync[1:0], MOSI};
            r_live      <= 1'b1;
            if (r_live && r_ssel_sync[0])
                r_armed <= 1'b1;

            if (w_ssel_fall && r_armed) begin
                r_in_frame <= 1'b1;
                r_bit_cnt  <= 6'd0;
                r_miso     <= r_result[7];
                r_tx       <= {r_result[6:0], 1'b0};
            end else if (w_ssel_rise) begin
                r_in_frame <= 1'b0;
                r_miso     <= 1'b0;
            end else if (r_in_frame) begin
                if (w_sck_rise) begin
                    r_shift <= {r_shift[38:0], r_mosi_sync[2]};
                    if (r_bit_cnt != 6'd63)
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                end
                if (w_sck_fall) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        w_op       = r_shift[39:32];
        w_arg      = r_shift[31:0];
        w_dec_ok   = 1'b0;
        w_dec_addr = A_START;
        w_dec_data = 32'd0;
        case (w_op)
            8'h01: begin w_dec_ok = 1'b1; w_dec_addr = A_START; w_dec_data = w_arg; end
            8'h02: begin w_dec_ok = 1'b1; w_dec_addr = A_SIZE;  w_dec_data = w_arg; end
            8'h03: begin w_dec_ok = 1'b1; w_dec_addr = A_VOL;   w_dec_data = {24'd0, w_arg[7:0]}; end
            8'h04: begin w_dec_ok = 1'b1; w_dec_addr = A_CMD;   w_dec_data = {29'd0, w_arg[2:0]}; end
`ifdef SNDCTL_VOLSTEP_EN
            8'h05: begin w_dec_ok = 1'b1; w_dec_addr = A_VOL;   w_dec_data = {24'd0, w_vol_up}; end
            8'h06: begin w_dec_ok = 1'b1; w_dec_addr = A_VOL;   w_dec_data = {24'd0, w_vol_dn}; end
`endif
            default: w_dec_ok = 1'b0;
        endcase
        if (r_bit_cnt != 6'd40)
            w_dec_ok = 1'b0;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_wren      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_wraddr    <= 16'd0;
            r_byteen    <= 4'd0;
            r_wdata     <= 32'd0;
            r_pend_addr <= 16'd0;
            r_pend_data <= 32'd0;
            r_result    <= 8'h00;
`ifdef SNDCTL_VOLSTEP_EN
            r_vol       <= 8'h00;
`endif
        end else begin
            r_wren      <= 1'b0;
            r_frame_err <= 1'b0;
            if (H_WREN) begin
                r_wren   <= 1'b1;
                r_wraddr <= H_WRADDR;
                r_byteen <= H_BYTEEN;
                r_wdata  <= H_WDATA;
`ifdef SNDCTL_VOLSTEP_EN
                if (H_WRADDR == A_VOL && H_BYTEEN[0])
                    r_vol <= H_WDATA[7:0];
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (w_frame_end)
                        r_state <= S_DECODE;
                    else if (r_in_frame)
                        r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_frame_end)
                        r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_dec_ok) begin
                        r_pend_addr <= w_dec_addr;
                        r_pend_data <= w_dec_data;
                        r_busy      <= 1'b1;
                        r_result    <= 8'hA5;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_result    <= 8'hEE;
                        r_state     <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // A second frame finishing here is dropped; the pending write stays intact.
                    if (w_frame_end) begin
                        r_frame_err <= 1'b1;
                        r_result    <= 8'hEE;
                    end
                    if (!H_WREN) begin
                        r_wren   <= 1'b1;
                        r_wraddr <= r_pend_addr;
                        r_byteen <= 4'hF;
                        r_wdata  <= r_pend_data;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
`ifdef SNDCTL_VOLSTEP_EN
                        if (r_pend_addr == A_VOL)
                            r_vol <= r_pend_data[7:0];
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign MISO      = r_miso;
    assign WREN      = r_wren;
    assign WRADDR    = r_wraddr;
    assign BYTEEN    = r_byteen;
    assign WDATA     = r_wdata;
    assign BUSY      = r_busy;
    assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_snd_spi_ctrl.sv
// tb_snd_spi_ctrl: directed SPI frames and host writes against hand-computed register writes and MISO bytes.
module tb_snd_spi_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        SCK, SSEL, MOSI, MISO;
    logic [15:0] H_WRADDR;
    logic [3:0]  H_BYTEEN;
    logic        H_WREN;
    logic [31:0] H_WDATA;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic        BUSY, FRAME_ERR;

    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    wr_t wq[$];
    int  ferr_cnt = 0;
    int  n_chk = 0;
    int  n_pass = 0;

    always #5 ACLK = ~ACLK;

    snd_spi_ctrl dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
        .H_WRADDR(H_WRADDR), .H_BYTEEN(H_BYTEEN), .H_WREN(H_WREN), .H_WDATA(H_WDATA),
        .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
        .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
    );

    always @(negedge ACLK) begin
        if (WREN)      wq.push_back({WRADDR, BYTEEN, WDATA});
        if (FRAME_ERR) ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic spi_shift(input logic [7:0] op, input logic [31:0] dat, input int nbits,
                             output logic [15:0] rx);
        logic [39:0] f;
        f  = {op, dat};
        rx = 16'h0000;
        SSEL = 1'b0;
        repeat (6) @(negedge ACLK);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 40) ? f[39-i] : 1'b0;
            repeat (6) @(negedge ACLK);
            if (i < 16) rx[15-i] = MISO;
            SCK = 1'b1;
            repeat (6) @(negedge ACLK);
            SCK = 1'b0;
        end
        repeat (6) @(negedge ACLK);
    endtask

    task automatic spi_xfer(input logic [7:0] op, input logic [31:0] dat, input int nbits,
                            output logic [15:0] rx);
        spi_shift(op, dat, nbits, rx);
        SSEL = 1'b1;
        repeat (12) @(negedge ACLK);
    endtask

    task automatic spi_expect(input string tag, input logic [7:0] op, input logic [31:0] dat,
                              input logic [7:0] rx_exp, input logic [15:0] a_exp,
                              input logic [31:0] d_exp);
        logic [15:0] rx;
        int ferr0;
        wq.delete();
        ferr0 = ferr_cnt;
        spi_xfer(op, dat, 40, rx);
        chk({tag, "_miso"}, 64'(rx), {48'd0, rx_exp, 8'h00});
        chk({tag, "_nwr"}, 64'(wq.size()), 64'd1);
        if (wq.size() > 0) chk({tag, "_wr"}, 64'(wq[0]), {12'd0, a_exp, 4'hF, d_exp});
        chk({tag, "_ferr"}, 64'(ferr_cnt - ferr0), 64'd0);
    endtask

    task automatic spi_reject(input string tag, input logic [7:0] op, input logic [31:0] dat,
                              input int nbits, input logic [7:0] rx_exp);
        logic [15:0] rx;
        int ferr0;
        wq.delete();
        ferr0 = ferr_cnt;
        spi_xfer(op, dat, nbits, rx);
        chk({tag, "_miso"}, 64'(rx), {48'd0, rx_exp, 8'h00});
        chk({tag, "_nwr"}, 64'(wq.size()), 64'd0);
        chk({tag, "_ferr"}, 64'(ferr_cnt - ferr0), 64'd1);
    endtask

    task automatic host_wr(input string tag, input logic [15:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        H_WREN = 1'b1; H_WRADDR = a; H_BYTEEN = be; H_WDATA = d;
        @(negedge ACLK);
        H_WREN = 1'b0;
        chk(tag, {11'd0, WREN, WRADDR, BYTEEN, WDATA}, {11'd0, 1'b1, a, be, d});
    endtask

    initial begin
        #600000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [15:0] rx;
        int ferr0, nspi;
        wr_t last;

        ARESETN = 1'b0; SCK = 1'b0; SSEL = 1'b1; MOSI = 1'b0;
        H_WREN = 1'b0; H_WRADDR = 16'h0; H_BYTEEN = 4'h0; H_WDATA = 32'h0;
        repeat (4) @(negedge ACLK);
        chk("rst_ctrl", {BUSY, WREN, FRAME_ERR, MISO}, 4'b0000);
        chk("rst_bus", {WRADDR, BYTEEN, WDATA}, 52'd0);
        ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);
        chk("idle_ctrl", {BUSY, WREN, FRAME_ERR, MISO}, 4'b0000);

        // basic writes; first MISO byte is the reset result 00
        spi_expect("f01", 8'h01, 32'h0000_0000, 8'h00, 16'h3000, 32'h0000_0000);
        spi_expect("f02", 8'h02, 32'h03C8_F000, 8'hA5, 16'h3004, 32'h03C8_F000);
        chk("miso_idle", 64'(MISO), 64'd0);
        spi_expect("f04x", 8'h04, 32'hFFFF_FFFF, 8'hA5, 16'h300C, 32'h0000_0007);
        spi_expect("f03x", 8'h03, 32'hFFFF_FF5A, 8'hA5, 16'h3008, 32'h0000_005A);

        // host contention: host writes win, SPI write follows the cycle after H_WREN drops
        wq.delete();
        spi_shift(8'h04, 32'h0000_0005, 40, rx);
        chk("f04_miso", 64'(rx), {48'd0, 8'hA5, 8'h00});
        SSEL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            H_WREN = 1'b1; H_WRADDR = 16'h3010; H_BYTEEN = 4'h3; H_WDATA = 32'h1000 + i;
            @(negedge ACLK);
            chk("host_lat", {11'd0, WREN, WRADDR, BYTEEN, WDATA},
                {11'd0, 1'b1, 16'h3010, 4'h3, 32'h1000 + i});
            if (i >= 4) chk("busy_hold", 64'(BUSY), 64'd1);
        end
        H_WREN = 1'b0;
        @(negedge ACLK);
        chk("spi_after_host", {11'd0, WREN, WRADDR, BYTEEN, WDATA},
            {11'd0, 1'b1, 16'h300C, 4'hF, 32'h0000_0005});
        @(negedge ACLK);
        chk("wren_drop_hold", {11'd0, WREN, BUSY, WRADDR, BYTEEN, WDATA},
            {11'd0, 2'b00, 16'h300C, 4'hF, 32'h0000_0005});
        repeat (10) @(negedge ACLK);

        // unknown opcode and wrong bit counts
        spi_reject("op07", 8'h07, 32'h1234_5678, 40, 8'hA5);
        spi_reject("len39", 8'h01, 32'h1111_1111, 39, 8'hEE);
        spi_reject("len41", 8'h01, 32'h1111_1111, 41, 8'hEE);
        spi_expect("after_err", 8'h03, 32'h0000_0042, 8'hEE, 16'h3008, 32'h0000_0042);

        // frame completing while a write is pending
        wq.delete();
        ferr0 = ferr_cnt;
        H_WREN = 1'b1; H_WRADDR = 16'h3010; H_BYTEEN = 4'hF; H_WDATA = 32'hDEAD_0000;
        spi_xfer(8'h01, 32'h1111_1111, 40, rx);
        spi_xfer(8'h02, 32'h2222_2222, 40, rx);
        chk("busy_pend", 64'(BUSY), 64'd1);
        chk("busy_miso", 64'(rx), {48'd0, 8'hA5, 8'h00});
        H_WREN = 1'b0;
        repeat (4) @(negedge ACLK);
        chk("busy_ferr", 64'(ferr_cnt - ferr0), 64'd1);
        nspi = 0;
        last = '0;
        for (int k = 0; k < wq.size(); k++) begin
            if (wq[k].a != 16'h3010) begin
                nspi++;
                last = wq[k];
            end
        end
        chk("busy_nspi", 64'(nspi), 64'd1);
        chk("busy_wr", 64'(last), {12'd0, 16'h3000, 4'hF, 32'h1111_1111});
        spi_expect("after_busy", 8'h02, 32'h0000_0033, 8'hEE, 16'h3004, 32'h0000_0033);

`ifdef SNDCTL_VOLSTEP_EN
        host_wr("hvol_f8", 16'h3008, 4'hF, 32'h0000_00F8);
        spi_expect("volup1", 8'h05, 32'h0, 8'hA5, 16'h3008, 32'h0000_00FF);
        spi_expect("volup2", 8'h05, 32'h0, 8'hA5, 16'h3008, 32'h0000_00FF);
        spi_expect("voldn1", 8'h06, 32'h0, 8'hA5, 16'h3008, 32'h0000_00EF);
        host_wr("hvol_00", 16'h3008, 4'hF, 32'h0000_0000);
        spi_expect("voldn0", 8'h06, 32'h0, 8'hA5, 16'h3008, 32'h0000_0000);
        host_wr("hvol_nobe0", 16'h3008, 4'hE, 32'h0000_0080);
        spi_expect("volup0", 8'h05, 32'h0, 8'hA5, 16'h3008, 32'h0000_0010);
`else
        spi_reject("op05", 8'h05, 32'h0, 40, 8'hA5);
        spi_reject("op06", 8'h06, 32'h0, 40, 8'hEE);
        spi_expect("after_vol", 8'h01, 32'h0000_0077, 8'hEE, 16'h3000, 32'h0000_0077);
`endif

        // reset in the middle of a frame
        wq.delete();
        ferr0 = ferr_cnt;
        fork
            spi_xfer(8'h03, 32'h0000_00FF, 40, rx);
            begin
                repeat (6 + 20 * 12) @(negedge ACLK);
                ARESETN = 1'b0;
                repeat (2) @(negedge ACLK);
                ARESETN = 1'b1;
            end
        join
        chk("rstmid_nwr", 64'(wq.size()), 64'd0);
        chk("rstmid_busy", 64'(BUSY), 64'd0);
        chk("rstmid_ferr", 64'(ferr_cnt - ferr0), 64'd0);
        spi_expect("rstmid_next", 8'h01, 32'hCAFE_F00D, 8'h00, 16'h3000, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
